// File: rtl/adc_sample_source_if.sv
// Serial ADC pin bundle (LTC2308-style converter).
//   convst : conversion start, controller -> ADC
//   sck    : serial clock, controller -> ADC, idles low
//   sdi    : config word, controller -> ADC, MSB first
//   sdo    : conversion result, ADC -> controller, MSB first
// master = the sequencing controller, slave = the ADC (or its model).
interface adc_sample_source_if;
   logic convst;
   logic sck;
   logic sdi;
   logic sdo;

   modport master (output convst, output sck, output sdi, input sdo);
   modport slave  (input convst, input sck, input sdi, output sdo);
endinterface

// File: rtl/adc_sample_source.sv
// adc_sample_source
// Fixed-rate conversion sequencer for a serial ADC. Each frame pulses CONVST,
// waits out the conversion, shifts 12 result bits in while shifting a 6-bit
// config word out, publishes the sample and raises a widened strobe.
// Ports:
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   enable_i      1 = run frames continuously, 0 = stop after current frame
//   channel_i     ADC input select, latched at frame start
//   adc           ADC pin bundle (master side)
//   sample_dat_o  last completed 12-bit sample
//   sample_tr_o   new-sample strobe, STROBE_CYCLES wide
//   busy_o        high from frame start until the strobe ends
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for enable and the frame-rate counter
// CONVST  | ADC convst high for CONVST_CYCLES
// WAIT    | conversion time, CONV_CYCLES
// SHIFT   | 12 SCK periods: SDI config out, SDO result in
// LOAD    | result published on sample_dat_o (one cycle before strobe)
// STROBE  | sample_tr_o high for STROBE_CYCLES
module adc_sample_source #(
   parameter int unsigned SCK_DIV       = 4,
   parameter int unsigned CONVST_CYCLES = 2,
   parameter int unsigned CONV_CYCLES   = 80,
   parameter int unsigned STROBE_CYCLES = 4,
   parameter int unsigned FRAME_CYCLES  = 1000
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        enable_i,
   input  logic [2:0]                  channel_i,
   adc_sample_source_if.master         adc,
   output logic [11:0]                 sample_dat_o,
   output logic                        sample_tr_o,
   output logic                        busy_o
);

   localparam int unsigned M1      = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
   localparam int unsigned CNT_MAX = (M1 > STROBE_CYCLES) ? M1 : STROBE_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam int DW = $clog2(SCK_DIV + 1);
   localparam int FW = $clog2(FRAME_CYCLES + 1);

   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONVST = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_LOAD   = 3'd4,
      ST_STROBE = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] div_q, div_d;
   logic [4:0]    half_q, half_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          arm_q, arm_d;
   logic [5:0]    cfg_q, cfg_d;
   logic [11:0]   rx_q, rx_d;
   logic [11:0]   dat_q, dat_d;
   logic          start_ok;
   logic          begin_frame;

   // arm_q lets the first frame after reset (or after sitting idle with
   // enable low) start immediately instead of waiting for the rate counter.
   assign start_ok = enable_i && (arm_q || (frame_q == FRAME_LAST));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      half_d      = half_q;
      frame_d     = frame_q;
      arm_d       = arm_q;
      cfg_d       = cfg_q;
      rx_d        = rx_q;
      dat_d       = dat_q;
      begin_frame = 1'b0;

      if (frame_q != FRAME_LAST) begin
         frame_d = frame_q + FW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (!enable_i) begin
               arm_d = 1'b1;
            end
            begin_frame = start_ok;
         end
         ST_CONVST: begin
            if (cnt_q == '0) begin
               state_d = ST_WAIT;
               cnt_d   = CW'(CONV_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_SHIFT;
               div_d   = DW'(SCK_DIV - 1);
               half_d  = 5'd23;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_SHIFT: begin
            // half_q counts SCK half-periods down from 23; odd = SCK low.
            if (div_q == '0) begin
               div_d = DW'(SCK_DIV - 1);
               if (half_q[0]) begin
                  rx_d = {rx_q[10:0], adc.sdo};
               end else begin
                  cfg_d = {cfg_q[4:0], 1'b0};
               end
               if (half_q == 5'd0) begin
                  state_d = ST_LOAD;
                  dat_d   = rx_q;
               end else begin
                  half_d = half_q - 5'd1;
               end
            end else begin
               div_d = div_q - DW'(1);
            end
         end
         ST_LOAD: begin
            state_d = ST_STROBE;
            cnt_d   = CW'(STROBE_CYCLES - 1);
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               state_d     = ST_IDLE;
               begin_frame = start_ok;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (begin_frame) begin
         state_d = ST_CONVST;
         cnt_d   = CW'(CONVST_CYCLES - 1);
         frame_d = '0;
         arm_d   = 1'b0;
         // single-ended, unipolar, no sleep; channel bits in ADC order
         cfg_d   = {1'b1, channel_i[0], channel_i[2], channel_i[1], 1'b1, 1'b0};
         rx_d    = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         half_q  <= '0;
         frame_q <= '0;
         arm_q   <= 1'b1;
         cfg_q   <= '0;
         rx_q    <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         half_q  <= half_d;
         frame_q <= frame_d;
         arm_q   <= arm_d;
         cfg_q   <= cfg_d;
         rx_q    <= rx_d;
         dat_q   <= dat_d;
      end
   end

   assign adc.convst   = (state_q == ST_CONVST);
   assign adc.sck      = (state_q == ST_SHIFT) && !half_q[0];
   assign adc.sdi      = (state_q == ST_SHIFT) && cfg_q[5];
   assign sample_dat_o = dat_q;
   assign sample_tr_o  = (state_q == ST_STROBE);
   assign busy_o       = (state_q != ST_IDLE);

endmodule
